// File: rtl/conv_link_pkg.sv
// conv_link_pkg: shared types and constants for the convolution link host.
// FSM states, link geometry and a byte-lane helper.
package conv_link_pkg;

  typedef enum logic [2:0] {
    LRST,
    IDLE,
    LOAD_W,
    LOAD_X,
    SETTLE,
    RD_LO,
    RD_HI,
    DONE
  } state_t;

  localparam int BYTES_PER_VEC = 4;
  localparam int FRAME_W       = 9;
  localparam int RES_W         = 18;
  localparam int LINK_RST_CYC  = 2;

  function automatic logic [7:0] byte_sel(
    input logic [31:0] v,
    input logic [1:0]  i
  );
    return v[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/conv_link_host_if.sv
// conv_link_host_if: pin bundle between the host and the convolution link.
// master = host side, slave = link side.
interface conv_link_host_if;
  import conv_link_pkg::*;

  logic [7:0]         link_data;
  logic               link_wsel;
  logic               link_rd;
  logic               link_rst_n;
  logic [FRAME_W-1:0] frm_data;
  logic               frm_phase;

  modport master (
    output link_data, link_wsel, link_rd, link_rst_n,
    input  frm_data, frm_phase
  );

  modport slave (
    input  link_data, link_wsel, link_rd, link_rst_n,
    output frm_data, frm_phase
  );

endinterface

// File: rtl/conv_frame_rx.sv
// conv_frame_rx: phase check and lo/hi capture of returned result frames.
// got_lo/got_hi/err are same-cycle decisions; res is the word as it will be.
module conv_frame_rx
  import conv_link_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_lo,
  input  logic               rd_hi,
  input  logic [FRAME_W-1:0] frm_data,
  input  logic               frm_phase,
  output logic               got_lo,
  output logic               got_hi,
  output logic               err,
  output logic [RES_W-1:0]   res
);

  logic [FRAME_W-1:0] lo, hi;
  logic               seen_hi;

  always_comb begin
    got_lo = rd_lo && !frm_phase;
    got_hi = rd_hi && frm_phase;
    err    = (rd_lo && frm_phase && seen_hi)
          || (rd_hi && !frm_phase);
    res    = {got_hi ? frm_data : hi, lo};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo      <= '0;
      hi      <= '0;
      seen_hi <= 1'b0;
    end else begin
      if (got_lo) lo <= frm_data;
      if (got_hi) hi <= frm_data;
      // a second hi-phase frame in a row is the error, not a new hunt
      seen_hi <= rd_lo && frm_phase && !seen_hi;
    end
  end

endmodule

// File: rtl/conv_link_host.sv
// conv_link_host: loads one (window, weights) job over the byte link and
// reassembles the 18-bit result. Optional weight cache: CONV_WEIGHT_CACHE_EN.
module conv_link_host
  import conv_link_pkg::*;
#(
  parameter int FRAME_LAT = 2,
  parameter int DISCARD   = 3,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_x,
  input  logic [31:0]      job_w,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_err,
  conv_link_host_if.master lnk
);

  localparam int SETTLE_CYC = FRAME_LAT + DISCARD;

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [3:0]       retry, retry_n;
  logic [31:0]      x_q, x_n, w_q, w_n;
  logic [7:0]       data_q, data_n;
  logic             rd_q, rd_n;
  logic             wsel_q, wsel_n;
  logic             lrst_q, lrst_n;
  logic             job_ready_n, res_valid_n, res_err_n;
  logic [RES_W-1:0] res_data_n;
  logic             skip_w;
  logic             got_lo, got_hi, rx_err;
  logic [RES_W-1:0] rx_res;

  conv_frame_rx u_rx (
    .clk       (clk),
    .rst       (rst),
    .rd_lo     (state == RD_LO),
    .rd_hi     (state == RD_HI),
    .frm_data  (lnk.frm_data),
    .frm_phase (lnk.frm_phase),
    .got_lo    (got_lo),
    .got_hi    (got_hi),
    .err       (rx_err),
    .res       (rx_res)
  );

`ifdef CONV_WEIGHT_CACHE_EN
  logic [31:0] cache_w;
  logic        cache_ok;

  always_ff @(posedge clk) begin
    if (rst || state == LRST) begin
      cache_ok <= 1'b0;
      cache_w  <= '0;
    end else if (state == LOAD_W) begin
      cache_ok <= 1'b1;
      cache_w  <= w_q;
    end
  end

  assign skip_w = cache_ok && (job_w == cache_w);
`else
  assign skip_w = 1'b0;
`endif

  // link outputs are registered from next-state values
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    retry_n    = retry;
    x_n        = x_q;
    w_n        = w_q;
    data_n     = 8'h00;
    rd_n       = 1'b1;
    wsel_n     = 1'b0;
    lrst_n     = 1'b1;
    res_data_n = res_data;
    res_err_n  = res_err;
    unique case (state)
      LRST: begin
        cnt_n  = cnt + 4'd1;
        lrst_n = 1'b0;
        if (cnt == 4'(LINK_RST_CYC - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          lrst_n  = 1'b1;
        end
      end
      IDLE: begin
        if (job_valid && job_ready) begin
          x_n     = job_x;
          w_n     = job_w;
          cnt_n   = '0;
          retry_n = '0;
          rd_n    = 1'b0;
          if (skip_w) begin
            state_n = LOAD_X;
            data_n  = byte_sel(job_x, 2'd0);
          end else begin
            state_n = LOAD_W;
            wsel_n  = 1'b1;
            data_n  = byte_sel(job_w, 2'd0);
          end
        end
      end
      LOAD_W: begin
        rd_n  = 1'b0;
        cnt_n = cnt + 4'd1;
        if (cnt == 4'(BYTES_PER_VEC - 1)) begin
          state_n = LOAD_X;
          cnt_n   = '0;
          data_n  = byte_sel(x_q, 2'd0);
        end else begin
          wsel_n = 1'b1;
          data_n = byte_sel(w_q, cnt[1:0] + 2'd1);
        end
      end
      LOAD_X: begin
        cnt_n = cnt + 4'd1;
        if (cnt == 4'(BYTES_PER_VEC - 1)) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end else begin
          rd_n   = 1'b0;
          data_n = byte_sel(x_q, cnt[1:0] + 2'd1);
        end
      end
      SETTLE: begin
        cnt_n = cnt + 4'd1;
        if (cnt == 4'(SETTLE_CYC - 1)) begin
          state_n = RD_LO;
          cnt_n   = '0;
        end
      end
      RD_LO, RD_HI: begin
        if (rx_err) begin
          retry_n = retry + 4'd1;
          if (int'(retry_n) < MAX_RETRY) begin
            state_n = RD_LO;
          end else begin
            state_n    = DONE;
            res_err_n  = 1'b1;
            res_data_n = rx_res;
          end
        end else if (got_lo) begin
          state_n = RD_HI;
        end else if (got_hi) begin
          state_n    = DONE;
          res_err_n  = 1'b0;
          res_data_n = rx_res;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_n = IDLE;
          retry_n = '0;
        end
      end
      default: state_n = LRST;
    endcase
    job_ready_n = (state_n == IDLE);
    res_valid_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LRST;
      cnt       <= '0;
      retry     <= '0;
      x_q       <= '0;
      w_q       <= '0;
      data_q    <= '0;
      rd_q      <= 1'b1;
      wsel_q    <= 1'b0;
      lrst_q    <= 1'b0;
      job_ready <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      x_q       <= x_n;
      w_q       <= w_n;
      data_q    <= data_n;
      rd_q      <= rd_n;
      wsel_q    <= wsel_n;
      lrst_q    <= lrst_n;
      job_ready <= job_ready_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      res_err   <= res_err_n;
    end
  end

  assign lnk.link_data  = data_q;
  assign lnk.link_rd    = rd_q;
  assign lnk.link_wsel  = wsel_q;
  assign lnk.link_rst_n = lrst_q;

endmodule

// File: tb/tb_conv_link_host.sv
// tb_conv_link_host: directed + random jobs against a behavioural link model.
// Build with CONV_WEIGHT_CACHE_EN defined to exercise the weight cache.
module tb_conv_link_host;
  import conv_link_pkg::*;

`ifdef CONV_WEIGHT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int SKIP = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_x = '0;
  logic [31:0] job_w = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [17:0] res_data;
  logic        res_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_link_host_if lnk();

  conv_link_host dut (
    .clk       (clk),
    .rst       (rst),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_x     (job_x),
    .job_w     (job_w),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .lnk       (lnk)
  );

  // behavioural link: 4-byte shift vectors, frames alternate lo/hi
  logic [7:0]  wv [4];
  logic [7:0]  xv [4];
  int          k = 0;
  logic [31:0] rnd = '0;
  int          flip_k = -1;
  bit          all_hi = 1'b0;
  logic [8:0]  shift_log [$];
  logic [8:0]  fd;
  logic        fp;
  int unsigned dot_now;

  always @(posedge clk) begin
    rnd <= $urandom;
    if (lnk.link_rst_n === 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        wv[i] <= '0;
        xv[i] <= '0;
      end
      k <= 0;
    end else if (lnk.link_rd === 1'b0) begin
      shift_log.push_back({lnk.link_wsel, lnk.link_data});
      if (lnk.link_wsel) begin
        for (int i = 0; i < 3; i++) wv[i] <= wv[i+1];
        wv[3] <= lnk.link_data;
      end else begin
        for (int i = 0; i < 3; i++) xv[i] <= xv[i+1];
        xv[3] <= lnk.link_data;
      end
      k <= 0;
    end else if (k < 1000) begin
      k <= k + 1;
    end
  end

  always_comb begin
    dot_now = 0;
    for (int i = 0; i < 4; i++)
      dot_now += 32'(wv[i]) * 32'(xv[i]);
    fp = 1'b0;
    fd = '0;
    if (k < SKIP) begin
      fp = rnd[9];
      fd = rnd[8:0];
    end else begin
      fp = ((k - SKIP) % 2) == 1;
      if (k == flip_k) fp = ~fp;
      if (all_hi) fp = 1'b1;
      fd = fp ? dot_now[17:9] : dot_now[8:0];
    end
  end

  assign lnk.frm_data  = fd;
  assign lnk.frm_phase = fp;

  bit          cache_ok_m = 1'b0;
  logic [31:0] cache_w_m = '0;

  function automatic int unsigned ref_dot(
    input logic [31:0] x,
    input logic [31:0] w
  );
    int unsigned s = 0;
    for (int i = 0; i < 4; i++)
      s += 32'(x[8*i +: 8]) * 32'(w[8*i +: 8]);
    return s;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!job_ready && n < 50) begin
      tick;
      n++;
    end
    chk("job_ready_wait", 64'(job_ready), 64'd1);
  endtask

  task automatic do_job(
    input logic [31:0] x,
    input logic [31:0] w,
    input int          hold,
    input int          exp_lat,
    input bit          exp_err,
    input bit          chk_data
  );
    int         lat;
    bit         hit;
    logic [8:0] exp_q [$];
    wait_ready();
    hit = CACHE && cache_ok_m && (w == cache_w_m);
    exp_q.delete();
    if (!hit)
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, w[8*i +: 8]});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, x[8*i +: 8]});
    shift_log.delete();
    job_x = x;
    job_w = w;
    job_valid = 1'b1;
    lat = 0;
    do begin
      tick;
      lat++;
      job_valid = 1'b0;
    end while (!res_valid && lat < 100);
    chk("latency", 64'(lat), 64'(exp_lat - (hit ? 4 : 0)));
    chk("res_err", 64'(res_err), 64'(exp_err));
    if (chk_data) chk("res_data", 64'(res_data), 64'(ref_dot(x, w)));
    chk("shift_cnt", 64'(shift_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < shift_log.size())
        chk("shift_byte", 64'(shift_log[i]), 64'(exp_q[i]));
    for (int i = 0; i < hold; i++) begin
      job_valid = 1'b1;
      job_x = $urandom;
      job_w = $urandom;
      tick;
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_ready", 64'(job_ready), 64'd0);
      if (chk_data)
        chk("hold_data", 64'(res_data), 64'(ref_dot(x, w)));
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("res_drop", 64'(res_valid), 64'd0);
    chk("ready_back", 64'(job_ready), 64'd1);
    cache_ok_m = 1'b1;
    cache_w_m = w;
  endtask

  initial begin
    logic [31:0] wr, xr;
    tick;
    tick;
    chk("rst_rd", 64'(lnk.link_rd), 64'd1);
    chk("rst_wsel", 64'(lnk.link_wsel), 64'd0);
    chk("rst_data", 64'(lnk.link_data), 64'd0);
    chk("rst_lrst", 64'(lnk.link_rst_n), 64'd0);
    chk("rst_jrdy", 64'(job_ready), 64'd0);
    chk("rst_rv", 64'(res_valid), 64'd0);
    chk("rst_rdata", 64'(res_data), 64'd0);
    chk("rst_rerr", 64'(res_err), 64'd0);
    rst = 1'b0;
    tick;
    chk("lrst_hold", 64'(lnk.link_rst_n), 64'd0);
    chk("lrst_jrdy", 64'(job_ready), 64'd0);
    tick;
    chk("lrst_end", 64'(lnk.link_rst_n), 64'd1);
    chk("idle_jrdy", 64'(job_ready), 64'd1);

    do_job(32'h04030201, 32'h01010101, 0, 16, 1'b0, 1'b1);
    chk("t1_value", 64'(res_data), 64'd10);

    do_job(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 16, 1'b0, 1'b1);
    chk("t2_lo", 64'(res_data[8:0]), 64'h004);
    chk("t2_hi", 64'(res_data[17:9]), 64'h1FC);

    flip_k = SKIP + 1;
    do_job($urandom, $urandom, 0, 18, 1'b0, 1'b1);
    flip_k = -1;

    all_hi = 1'b1;
    do_job($urandom, $urandom, 0, 20, 1'b1, 1'b0);
    all_hi = 1'b0;

    do_job($urandom, $urandom, 10, 16, 1'b0, 1'b1);

    wait_ready();
    job_x = $urandom;
    job_w = ~cache_w_m;
    job_valid = 1'b1;
    tick;
    job_valid = 1'b0;
    repeat (5) tick;
    chk("ldx_rd", 64'(lnk.link_rd), 64'd0);
    chk("ldx_wsel", 64'(lnk.link_wsel), 64'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cache_ok_m = 1'b0;
    chk("mid_lrst1", 64'(lnk.link_rst_n), 64'd0);
    chk("mid_rd1", 64'(lnk.link_rd), 64'd1);
    chk("mid_rv", 64'(res_valid), 64'd0);
    tick;
    chk("mid_lrst2", 64'(lnk.link_rst_n), 64'd0);
    chk("mid_rd2", 64'(lnk.link_rd), 64'd1);
    tick;
    chk("mid_lrst_end", 64'(lnk.link_rst_n), 64'd1);
    do_job($urandom, $urandom, 0, 16, 1'b0, 1'b1);

    wr = $urandom;
    do_job($urandom, wr, 0, 16, 1'b0, 1'b1);
    do_job($urandom, wr, 0, 16, 1'b0, 1'b1);

    for (int j = 0; j < 6; j++) begin
      xr = $urandom;
      if ($urandom_range(1, 0) == 1) wr = $urandom;
      do_job(xr, wr, $urandom_range(3, 0), 16, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
